l1_tags_nway: RTL and testbench
===============================

// Module: l1_tags_nway
// PURPOSE
//  Parametrised N-way set-associative L1 tag store (IL1/DL1) with tree pseudo-LRU replacement.
//  Serves a lookup/allocate port, a full-clear port and a snoop-invalidate port; sits beside
//  the L1 data array and tells the cache controller hit/miss and the way to read or fill.
//  Successor of the fixed 2-way tag block: configurable ways/sets, optional write-allocate,
//  automatic init sweep after reset.
// PARAMETERS
//  NR_WAYS    4   ways per set; legal values 2 or 4.
//  SETS_LOG2  6   log2(sets); legal values 6..9.
//  LINE_LOG2  5   log2(line bytes).
//  WR_ALLOC   0   1: write miss allocates like a read miss; 0: write miss leaves tags untouched.
//  Derived: WAY_W = log2(NR_WAYS); TAG_W = 32-SETS_LOG2-LINE_LOG2 (21 by default).
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      asynchronous reset, active low
//  i_acc_req  in   1      lookup request; held until o_acc_ack
//  i_acc_adr  in   32     lookup address; index=[LINE_LOG2+:SETS_LOG2], tag=[31-:TAG_W]
//  i_acc_wen  in   1      1 = write access
//  o_acc_ack  out  1      one-cycle pulse; o_acc_hit/o_acc_way are valid in this cycle
//  o_acc_hit  out  1      1 = hit
//  o_acc_way  out  WAY_W  hit way, or victim way on an allocating miss
//  i_clr_req  in   1      invalidate all lines; held until o_clr_ack
//  o_clr_ack  out  1      one-cycle pulse at the end of the sweep
//  i_inv_req  in   1      invalidate one line; held until o_inv_ack
//  i_inv_adr  in   32     invalidate address
//  o_inv_ack  out  1      one-cycle pulse
//  o_busy     out  1      1 while not in Idle (includes the init sweep)
// BEHAVIOUR
//  - Reset: state=Init, clear counter=0, all PLRU bits=0. o_acc_ack/o_acc_hit/o_acc_way/
//    o_clr_ack/o_inv_ack=0, o_busy=1.
//  - Storage: tag+valid in a sync-read RAM (1-cycle read latency), one entry per set/way.
//    PLRU bits are in flops (NR_WAYS-1 per set) and are cleared by async reset.
//  - States: Init, Idle, AccMatch, InvMatch, Update, Invalid, Clear.
//    Init:     writes valid=0 to set clr_cnt each cycle; goes to Idle after set 2^SETS_LOG2-1.
//              Init never pulses o_clr_ack.
//    Idle:     request priority is acc > inv > clr. Goes to AccMatch, InvMatch or Clear.
//              The RAM address is driven combinationally from the winning address.
//    AccMatch: pulses o_acc_ack.
//              hit -> Update (PLRU touch).
//              miss & (~wen | WR_ALLOC) -> Update (install tag, valid=1 in victim, PLRU touch).
//              write miss & ~WR_ALLOC -> Idle.
//              The RAM/PLRU write is committed on the AccMatch->Update edge.
//    Update:   one-cycle bubble -> Idle. Requests are not sampled.
//    InvMatch: hit -> Invalid (clear valid of the hit way; PLRU unchanged).
//              miss -> pulse o_inv_ack -> Idle.
//    Invalid:  pulses o_inv_ack -> Idle.
//    Clear:    same sweep as Init; pulses o_clr_ack in the last-set cycle -> Idle.
//              PLRU bits are also zeroed.
//  - Latency from req seen in Idle (cycle 0):
//    acc ack at cycle 1; next accept at cycle 3, or cycle 2 for a non-allocating write miss.
//    inv miss ack at cycle 1; inv hit ack at cycle 2.
//    clr ack at cycle 2^SETS_LOG2.
//  - Requesters drop req the cycle after ack. A req still high in Update or Idle is treated
//    as a new request.
//  - Victim selection: lowest-index invalid way first; otherwise the PLRU tree.
//    NR_WAYS=4: b0=0 selects the {0,1} half, else {2,3}. b1 selects within {0,1}, b2 within {2,3}.
//    Touch of way w: b0=~w[1]; if w<2 then b1=~w[0], else b2=~w[0].
//    NR_WAYS=2: a single bit b0 is the victim index; touch sets b0=~w.
//  - Multiple valid matches in one set are illegal. RTL reports the lowest way; an assertion fires.
//  - rst_n asserted in any state aborts immediately to Init; no pending ack is issued.
//  - i_clr_req arriving during Init is served by a separate Clear pass after Init completes.
// STRUCTURE
//  - l1_tags_defs.vh: state encodings (one-hot), legal-value checks, TAG_W/WAY_W macros.
//  - Sub-module l1_plru: combinational victim select plus touch-update of one set's PLRU
//    vector, parametrised by NR_WAYS.
//  - Tag RAM is the existing BRAM wrapper (or inferred array); no other sub-modules.
// TESTING (defaults: NR_WAYS=4, SETS_LOG2=6, WR_ALLOC=0)
//  1 Release rst_n -> o_busy=1 for 64 cycles. Read 0x0000_1000 -> ack hit=0 way=0.
//    Repeat the read -> hit=1 way=0.
//  2 Read 0x0000_0000, 0x0800, 0x1000, 0x1800 (set 0) -> ways 0,1,2,3.
//    Read 0x0 -> hit way 0. Read 0x2000 -> miss, victim way=2.
//  3 Write 0x0000_4000 (miss) -> ack hit=0, Idle at cycle 2.
//    Read 0x4000 -> miss (no allocation). With WR_ALLOC=1, the same read -> hit.
//  4 Inv 0x0000_0800 after test 2 -> o_inv_ack at cycle 2; read 0x0800 -> miss, way=1.
//    Inv 0x0000_9000 (absent) -> ack at cycle 1.
//  5 acc 0x20 and inv 0x20 raised together in Idle -> acc acked first, inv acked next.
//    Then clr -> o_clr_ack after 64 cycles; all later reads miss.
//  6 rst_n pulsed low mid-Clear (counter=30) -> acks stay 0; full 64-cycle Init; no o_clr_ack.

Source files
------------

// File: rtl/l1_tags_nway_pkg.sv
// Shared definitions for the N-way L1 tag store: controller states and address-split helpers.
package l1_tags_nway_pkg;

  localparam int unsigned ADR_W = 32;

  // One-hot controller states
  typedef enum logic [6:0] {
    ST_INIT      = 7'b000_0001,
    ST_IDLE      = 7'b000_0010,
    ST_ACC_MATCH = 7'b000_0100,
    ST_INV_MATCH = 7'b000_1000,
    ST_UPDATE    = 7'b001_0000,
    ST_INVALID   = 7'b010_0000,
    ST_CLEAR     = 7'b100_0000
  } state_e;

  // Tag width left over once the set index and line offset are removed
  function automatic int unsigned tag_width(input int unsigned sets_log2,
                                            input int unsigned line_log2);
    return ADR_W - sets_log2 - line_log2;
  endfunction

endpackage

// File: rtl/l1_tags_nway_plru.sv
// Tree pseudo-LRU for one set: picks the victim way and computes the bits after touching a way.
//   bits      : current PLRU vector of the set (NR_WAYS-1 bits)
//   valid     : valid flags of the set; an invalid way is always preferred as victim
//   touch_way : way being used this access
//   victim    : lowest invalid way, else the way the tree points at
//   bits_next : PLRU vector after touching touch_way
module l1_tags_nway_plru #(
  parameter int unsigned NR_WAYS = 4
) (
  input  logic [NR_WAYS-2:0]         bits,
  input  logic [NR_WAYS-1:0]         valid,
  input  logic [$clog2(NR_WAYS)-1:0] touch_way,
  output logic [$clog2(NR_WAYS)-1:0] victim,
  output logic [NR_WAYS-2:0]         bits_next
);

  localparam int unsigned WAY_W = $clog2(NR_WAYS);

  logic [WAY_W-1:0] tree_way;

  if (NR_WAYS == 4) begin : g_w4
    // b0 picks the half, b1/b2 pick within {0,1}/{2,3}
    always_comb begin
      tree_way = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
    end

    // Point the tree away from the touched way
    always_comb begin
      bits_next    = bits;
      bits_next[0] = ~touch_way[1];
      if (!touch_way[1]) bits_next[1] = ~touch_way[0];
      else               bits_next[2] = ~touch_way[0];
    end
  end else begin : g_w2
    always_comb begin
      tree_way = bits[0];
    end

    always_comb begin
      bits_next = ~touch_way;
    end
  end

  // Lowest-index invalid way overrides the tree
  always_comb begin
    victim = tree_way;
    for (int w = NR_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/l1_tags_nway.sv
// N-way set-associative L1 tag store with tree PLRU, snoop invalidate and full clear.
//   clk, rst_n                     : clock, async active-low reset (enters the init sweep)
//   i_acc_req/adr/wen, o_acc_*     : lookup/allocate port; ack carries hit and way
//   i_clr_req, o_clr_ack           : invalidate every line; ack at the end of the sweep
//   i_inv_req/adr, o_inv_ack       : invalidate one line if present
//   o_busy                         : controller not idle (includes the init sweep)
// Legal configurations: NR_WAYS 2 or 4, SETS_LOG2 6..9.
module l1_tags_nway
  import l1_tags_nway_pkg::*;
#(
  parameter int unsigned NR_WAYS   = 4,
  parameter int unsigned SETS_LOG2 = 6,
  parameter int unsigned LINE_LOG2 = 5,
  parameter int unsigned WR_ALLOC  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_acc_req,
  input  logic [31:0]                i_acc_adr,
  input  logic                       i_acc_wen,
  output logic                       o_acc_ack,
  output logic                       o_acc_hit,
  output logic [$clog2(NR_WAYS)-1:0] o_acc_way,
  input  logic                       i_clr_req,
  output logic                       o_clr_ack,
  input  logic                       i_inv_req,
  input  logic [31:0]                i_inv_adr,
  output logic                       o_inv_ack,
  output logic                       o_busy
);

  localparam int unsigned WAY_W  = $clog2(NR_WAYS);
  localparam int unsigned TAG_W  = tag_width(SETS_LOG2, LINE_LOG2);
  localparam int unsigned ENT_W  = TAG_W + 1;
  localparam int unsigned SETS   = 1 << SETS_LOG2;
  localparam int unsigned PLRU_W = NR_WAYS - 1;

  state_e                          state;
  logic [SETS_LOG2-1:0]            clr_cnt;
  logic [ADR_W-1:0]                adr_q;
  logic                            wen_q;
  logic [NR_WAYS-1:0][ENT_W-1:0]   mem [SETS];
  logic [NR_WAYS-1:0][ENT_W-1:0]   rd_q;
  logic [PLRU_W-1:0]               plru_q [SETS];
  logic [PLRU_W-1:0]               plru_next;
  logic [SETS_LOG2-1:0]            ram_adr;
  logic                            ram_we;
  logic [NR_WAYS-1:0]              ram_wmask;
  logic [ENT_W-1:0]                ram_wdata;
  logic [SETS_LOG2-1:0]            idx_q;
  logic [TAG_W-1:0]                tag_q;
  logic [NR_WAYS-1:0]              valid;
  logic [NR_WAYS-1:0]              match;
  logic                            hit;
  logic                            alloc;
  logic                            sweep;
  logic                            sweep_last;
  logic [WAY_W-1:0]                hit_way;
  logic [WAY_W-1:0]                victim;
  logic [WAY_W-1:0]                acc_way;
  logic                            unused_lsb;

  assign idx_q      = adr_q[LINE_LOG2 +: SETS_LOG2];
  assign tag_q      = adr_q[ADR_W-1 -: TAG_W];
  assign unused_lsb = ^adr_q[LINE_LOG2-1:0];
  assign sweep      = (state == ST_INIT) || (state == ST_CLEAR);
  assign sweep_last = (clr_cnt == '1);

  // Tag compare on the RAM read data; lowest matching way wins
  always_comb begin
    valid   = '0;
    match   = '0;
    hit_way = '0;
    for (int w = NR_WAYS - 1; w >= 0; w--) begin
      valid[w] = rd_q[w][TAG_W];
      match[w] = rd_q[w][TAG_W] && (rd_q[w][TAG_W-1:0] == tag_q);
      if (match[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit     = |match;
  assign alloc   = !hit && (!wen_q || (WR_ALLOC != 0));
  assign acc_way = hit ? hit_way : victim;

  l1_tags_nway_plru #(
    .NR_WAYS (NR_WAYS)
  ) u_plru (
    .bits      (plru_q[idx_q]),
    .valid     (valid),
    .touch_way (acc_way),
    .victim    (victim),
    .bits_next (plru_next)
  );

  // RAM address/write control; address comes straight from the winning request in Idle
  always_comb begin
    ram_adr   = clr_cnt;
    ram_we    = 1'b0;
    ram_wmask = '0;
    ram_wdata = '0;
    case (state)
      ST_INIT, ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_wmask = '1;
      end
      ST_IDLE: begin
        if (i_acc_req)      ram_adr = i_acc_adr[LINE_LOG2 +: SETS_LOG2];
        else if (i_inv_req) ram_adr = i_inv_adr[LINE_LOG2 +: SETS_LOG2];
      end
      ST_ACC_MATCH: begin
        ram_adr = idx_q;
        if (alloc) begin
          ram_we    = 1'b1;
          ram_wmask = NR_WAYS'(1) << victim;
          ram_wdata = {1'b1, tag_q};
        end
      end
      ST_INV_MATCH: begin
        ram_adr = idx_q;
        if (hit) begin
          ram_we    = 1'b1;
          ram_wmask = NR_WAYS'(1) << hit_way;
        end
      end
      default: ;
    endcase
  end

  // Tag RAM: one row per set, per-way write enables, one-cycle read latency
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int w = 0; w < NR_WAYS; w++) begin
        if (ram_wmask[w]) mem[ram_adr][w] <= ram_wdata;
      end
    end
    rd_q <= mem[ram_adr];
  end

  // Controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
      adr_q   <= '0;
      wen_q   <= 1'b0;
    end else begin
      case (state)
        ST_INIT, ST_CLEAR: begin
          clr_cnt <= clr_cnt + SETS_LOG2'(1);
          if (sweep_last) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (i_acc_req) begin
            adr_q <= i_acc_adr;
            wen_q <= i_acc_wen;
            state <= ST_ACC_MATCH;
          end else if (i_inv_req) begin
            adr_q <= i_inv_adr;
            state <= ST_INV_MATCH;
          end else if (i_clr_req) begin
            state <= ST_CLEAR;
          end
        end
        ST_ACC_MATCH: state <= (hit || alloc) ? ST_UPDATE : ST_IDLE;
        ST_INV_MATCH: state <= hit ? ST_INVALID : ST_IDLE;
        ST_UPDATE:    state <= ST_IDLE;
        ST_INVALID:   state <= ST_IDLE;
        default:      state <= ST_INIT;
      endcase
    end
  end

  // PLRU flops: zeroed by reset and by a sweep, touched when an access commits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (sweep) begin
      plru_q[clr_cnt] <= '0;
    end else if ((state == ST_ACC_MATCH) && (hit || alloc)) begin
      plru_q[idx_q] <= plru_next;
    end
  end

  assign o_acc_ack = (state == ST_ACC_MATCH);
  assign o_acc_hit = o_acc_ack && hit;
  assign o_acc_way = o_acc_ack ? acc_way : '0;
  assign o_inv_ack = ((state == ST_INV_MATCH) && !hit) || (state == ST_INVALID);
  assign o_clr_ack = (state == ST_CLEAR) && sweep_last;
  assign o_busy    = (state != ST_IDLE);

  a_single_match: assert property (@(posedge clk) disable iff (!rst_n)
    ((state == ST_ACC_MATCH) || (state == ST_INV_MATCH)) |-> $onehot0(match));

endmodule

// File: tb/tb_l1_tags_nway.sv
// Directed bench for l1_tags_nway (4 ways, 64 sets, 32-byte lines, no write-allocate).
module tb_l1_tags_nway;

  localparam int WR_ALLOC = 0;

  logic        clk;
  logic        rst_n;
  logic        i_acc_req, i_acc_wen, i_clr_req, i_inv_req;
  logic [31:0] i_acc_adr, i_inv_adr;
  logic        o_acc_ack, o_acc_hit, o_clr_ack, o_inv_ack, o_busy;
  logic [1:0]  o_acc_way;

  int checks = 0;
  int passed = 0;
  int acc_seen = 0, inv_seen = 0, clr_seen = 0;
  int acc_exp = 0, inv_exp = 0, clr_exp = 0;

  // Reference contents: valid flag, tag and the three tree bits per set
  bit mv [64][4];
  int mt [64][4];
  int mb [64][3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  l1_tags_nway #(
    .NR_WAYS   (4),
    .SETS_LOG2 (6),
    .LINE_LOG2 (5),
    .WR_ALLOC  (WR_ALLOC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_acc_req (i_acc_req),
    .i_acc_adr (i_acc_adr),
    .i_acc_wen (i_acc_wen),
    .o_acc_ack (o_acc_ack),
    .o_acc_hit (o_acc_hit),
    .o_acc_way (o_acc_way),
    .i_clr_req (i_clr_req),
    .o_clr_ack (o_clr_ack),
    .i_inv_req (i_inv_req),
    .i_inv_adr (i_inv_adr),
    .o_inv_ack (o_inv_ack),
    .o_busy    (o_busy)
  );

  // Count every ack pulse seen, to catch spurious or stretched acks
  always @(negedge clk) begin
    acc_seen += int'(o_acc_ack);
    inv_seen += int'(o_inv_ack);
    clr_seen += int'(o_clr_ack);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic m_reset();
    for (int s = 0; s < 64; s++) begin
      for (int w = 0; w < 4; w++) begin
        mv[s][w] = 1'b0;
        mt[s][w] = 0;
      end
      for (int b = 0; b < 3; b++) mb[s][b] = 0;
    end
  endtask

  task automatic m_lookup(input int s, input int t, output int h, output int w);
    h = 0;
    w = 0;
    for (int k = 3; k >= 0; k--) begin
      if (mv[s][k] && mt[s][k] == t) begin
        h = 1;
        w = k;
      end
    end
  endtask

  function automatic int m_victim(input int s);
    for (int k = 0; k < 4; k++) if (!mv[s][k]) return k;
    if (mb[s][0] == 0) return mb[s][1];
    return 2 + mb[s][2];
  endfunction

  task automatic m_touch(input int s, input int w);
    mb[s][0] = (w < 2) ? 1 : 0;
    if (w < 2) mb[s][1] = 1 - (w % 2);
    else       mb[s][2] = 1 - (w % 2);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 200) begin
      cyc();
      n++;
    end
    if (n >= 200) chk("wait_idle busy", int'(o_busy), 0);
  endtask

  task automatic do_reset(input string nm);
    int n;
    rst_n     = 1'b0;
    i_acc_req = 1'b0;
    i_inv_req = 1'b0;
    i_clr_req = 1'b0;
    cyc();
    cyc();
    chk({nm, " rst busy"}, int'(o_busy), 1);
    chk({nm, " rst acc_ack"}, int'(o_acc_ack), 0);
    chk({nm, " rst acc_hit"}, int'(o_acc_hit), 0);
    chk({nm, " rst acc_way"}, int'(o_acc_way), 0);
    chk({nm, " rst inv_ack"}, int'(o_inv_ack), 0);
    chk({nm, " rst clr_ack"}, int'(o_clr_ack), 0);
    m_reset();
    rst_n = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (o_busy && n < 200);
    chk({nm, " init cycles"}, n, 64);
  endtask

  // Lookup; lit_* pin the model to hand-computed values (-1 = not pinned)
  task automatic acc(input logic [31:0] adr, input bit wen, input int lit_hit,
                     input int lit_way, input string nm);
    int s, t, mh, mw, n;
    bit al;
    s = int'(adr[10:5]);
    t = int'(adr[31:11]);
    m_lookup(s, t, mh, mw);
    if (mh == 0) mw = m_victim(s);
    al = (mh == 0) && (!wen || WR_ALLOC != 0);
    if (lit_hit >= 0) chk({nm, " model hit"}, mh, lit_hit);
    if (lit_way >= 0) chk({nm, " model way"}, mw, lit_way);
    wait_idle();
    i_acc_adr = adr;
    i_acc_wen = wen;
    i_acc_req = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!o_acc_ack && n < 20);
    i_acc_req = 1'b0;
    chk({nm, " ack cycle"}, n, 1);
    chk({nm, " hit"}, int'(o_acc_hit), mh);
    if (mh != 0 || al) chk({nm, " way"}, int'(o_acc_way), mw);
    acc_exp++;
    if (mh != 0) m_touch(s, mw);
    else if (al) begin
      mv[s][mw] = 1'b1;
      mt[s][mw] = t;
      m_touch(s, mw);
    end
    do begin
      cyc();
      n++;
    end while (o_busy && n < 20);
    chk({nm, " idle cycle"}, n, (mh != 0 || al) ? 3 : 2);
  endtask

  task automatic inv(input logic [31:0] adr, input int lit_cyc, input string nm);
    int s, t, mh, mw, n, want;
    s = int'(adr[10:5]);
    t = int'(adr[31:11]);
    m_lookup(s, t, mh, mw);
    want = (mh != 0) ? 2 : 1;
    if (lit_cyc >= 0) chk({nm, " model cycle"}, want, lit_cyc);
    wait_idle();
    i_inv_adr = adr;
    i_inv_req = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!o_inv_ack && n < 20);
    i_inv_req = 1'b0;
    chk({nm, " ack cycle"}, n, want);
    inv_exp++;
    if (mh != 0) mv[s][mw] = 1'b0;
    do begin
      cyc();
      n++;
    end while (o_busy && n < 20);
    chk({nm, " idle cycle"}, n, want + 1);
  endtask

  task automatic clr(input string nm);
    int n;
    wait_idle();
    i_clr_req = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!o_clr_ack && n < 200);
    i_clr_req = 1'b0;
    chk({nm, " ack cycle"}, n, 64);
    clr_exp++;
    m_reset();
    cyc();
    chk({nm, " idle after"}, int'(o_busy), 0);
  endtask

  initial begin
    int n, mh, mw;
    rst_n     = 1'b0;
    i_acc_req = 1'b0;
    i_acc_wen = 1'b0;
    i_acc_adr = '0;
    i_inv_req = 1'b0;
    i_inv_adr = '0;
    i_clr_req = 1'b0;

    // Reset, init sweep, first miss then hit
    do_reset("t1");
    acc(32'h0000_1000, 1'b0, 0, 0, "t1 rd miss");
    acc(32'h0000_1000, 1'b0, 1, 0, "t1 rd hit");

    // Fill set 0, hit, then PLRU victim
    do_reset("t2");
    acc(32'h0000_0000, 1'b0, 0, 0, "t2 fill0");
    acc(32'h0000_0800, 1'b0, 0, 1, "t2 fill1");
    acc(32'h0000_1000, 1'b0, 0, 2, "t2 fill2");
    acc(32'h0000_1800, 1'b0, 0, 3, "t2 fill3");
    acc(32'h0000_0000, 1'b0, 1, 0, "t2 hit0");
    acc(32'h0000_2000, 1'b0, 0, 2, "t2 plru victim");

    // Snoop invalidate hit and miss
    inv(32'h0000_0800, 2, "t4 inv hit");
    acc(32'h0000_0800, 1'b0, 0, 1, "t4 rd refill");
    inv(32'h0000_9000, 1, "t4 inv miss");

    // Write miss without allocation
    acc(32'h0000_4000, 1'b1, 0, -1, "t3 wr miss");
    acc(32'h0000_4000, 1'b0, 0, -1, "t3 rd after wr");

    // Simultaneous acc and inv: acc first, inv served after the update bubble
    wait_idle();
    m_lookup(1, 0, mh, mw);
    if (mh == 0) mw = m_victim(1);
    chk("t5 model way", mw, 0);
    i_acc_adr = 32'h0000_0020;
    i_acc_wen = 1'b0;
    i_inv_adr = 32'h0000_0020;
    i_acc_req = 1'b1;
    i_inv_req = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!o_acc_ack && n < 20);
    i_acc_req = 1'b0;
    chk("t5 acc ack cycle", n, 1);
    chk("t5 inv idle during acc", int'(o_inv_ack), 0);
    chk("t5 acc hit", int'(o_acc_hit), mh);
    chk("t5 acc way", int'(o_acc_way), mw);
    acc_exp++;
    mv[1][mw] = 1'b1;
    mt[1][mw] = 0;
    m_touch(1, mw);
    do begin
      cyc();
      n++;
    end while (!o_inv_ack && n < 20);
    i_inv_req = 1'b0;
    chk("t5 inv ack cycle", n, 5);
    inv_exp++;
    mv[1][mw] = 1'b0;

    // Full clear, then everything misses
    clr("t5 clr");
    acc(32'h0000_0000, 1'b0, 0, 0, "t5 rd0 after clr");
    acc(32'h0000_0800, 1'b0, 0, 1, "t5 rd800 after clr");
    acc(32'h0000_2000, 1'b0, 0, 2, "t5 rd2000 after clr");

    // Reset in the middle of a clear sweep
    wait_idle();
    i_clr_req = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (n < 31 && !o_clr_ack);
    chk("t6 no clr ack mid sweep", int'(o_clr_ack), 0);
    do_reset("t6");
    acc(32'h0000_1000, 1'b0, 0, 0, "t6 rd after reset");

    cyc();
    chk("acc ack pulses", acc_seen, acc_exp);
    chk("inv ack pulses", inv_seen, inv_exp);
    chk("clr ack pulses", clr_seen, clr_exp);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
